// File: rtl/rv32i_types.sv
// Shared RV32I back-end types: the common data bus entry and its field widths.
package rv32i_types;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;

    // One broadcast on the common data bus.
    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [AREG_W-1:0]    rd;
        logic [XLEN-1:0]      value;
    } cdb_entry_t;

    localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

endpackage

// File: rtl/cdb_rr_pick.sv
// Round-robin picker: starting at start_i and wrapping modulo NUM_FU, returns
// the first NUM_CDB requesters as one-hot picks (plus index) in scan order.
module cdb_rr_pick
    import rv32i_types::*;
#(
    parameter  int NUM_FU  = 4,
    parameter  int NUM_CDB = 2,
    localparam int PW      = $clog2(NUM_FU),
    localparam int CW      = $clog2(NUM_CDB + 1)
) (
    input  logic [NUM_FU-1:0]  req_i,
    input  logic [PW-1:0]      start_i,
    output logic [NUM_FU-1:0]  pick_oh_o  [NUM_CDB],
    output logic [PW-1:0]      pick_idx_o [NUM_CDB],
    output logic [NUM_CDB-1:0] pick_vld_o,
    output logic [CW-1:0]      pick_cnt_o
);

    // Walk every index once from the start pointer, filling slots in scan order.
    always_comb begin
        int            sum;
        logic [PW-1:0] idx;
        logic [CW-1:0] slot;
        sum        = 0;
        idx        = '0;
        slot       = '0;
        pick_vld_o = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            pick_oh_o[p]  = '0;
            pick_idx_o[p] = '0;
        end
        for (int off = 0; off < NUM_FU; off++) begin
            sum = int'(start_i) + off;
            if (sum >= NUM_FU) begin
                sum = sum - NUM_FU;
            end
            idx = PW'(sum);
            if (req_i[idx] && (int'(slot) < NUM_CDB)) begin
                pick_oh_o[slot][idx] = 1'b1;
                pick_idx_o[slot]     = idx;
                pick_vld_o[slot]     = 1'b1;
                slot                 = slot + 1'b1;
            end
        end
        pick_cnt_o = slot;
    end

endmodule

// File: rtl/cdb_rr_arb.sv
// Round-robin arbiter granting up to NUM_CDB functional units per cycle onto
// the common data bus. Optional macro CDB_ARB_OUT_REG_EN registers the
// broadcast ports (one cycle after grant); otherwise they are combinational.
module cdb_rr_arb
    import rv32i_types::*;
#(
    parameter  int NUM_FU  = 4,
    parameter  int NUM_CDB = 2,
    localparam int PW      = $clog2(NUM_FU),
    localparam int CW      = $clog2(NUM_CDB + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_FU-1:0]  fu_valid,
    input  cdb_entry_t         fu_entry [NUM_FU],
    output logic [NUM_FU-1:0]  fu_grant,
    input  logic               flush,
    output cdb_entry_t         cdb_out [NUM_CDB],
    output logic [NUM_CDB-1:0] cdb_valid,
    output logic [CW-1:0]      grant_cnt
);

    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      rr_ptr_d;
    logic [NUM_FU-1:0]  pick_oh  [NUM_CDB];
    logic [PW-1:0]      pick_idx [NUM_CDB];
    logic [NUM_CDB-1:0] pick_vld;
    logic [CW-1:0]      pick_cnt;
    logic               arb_en;
    cdb_entry_t         bcast_d [NUM_CDB];
    logic [NUM_CDB-1:0] bcast_vld_d;

    // Grants are suppressed while in reset or during a mispredict flush.
    assign arb_en = rst_n & ~flush;

    cdb_rr_pick #(
        .NUM_FU  (NUM_FU),
        .NUM_CDB (NUM_CDB)
    ) u_pick (
        .req_i      (fu_valid),
        .start_i    (rr_ptr_q),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx),
        .pick_vld_o (pick_vld),
        .pick_cnt_o (pick_cnt)
    );

    // Turn picks into grants and port payloads; the last pick sets the next pointer.
    always_comb begin
        fu_grant    = '0;
        grant_cnt   = '0;
        bcast_vld_d = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int p = 0; p < NUM_CDB; p++) begin
            bcast_d[p] = '0;
        end
        if (arb_en) begin
            grant_cnt = pick_cnt;
            for (int p = 0; p < NUM_CDB; p++) begin
                if (pick_vld[p]) begin
                    fu_grant       = fu_grant | pick_oh[p];
                    bcast_d[p]     = fu_entry[pick_idx[p]];
                    bcast_vld_d[p] = 1'b1;
                    rr_ptr_d       = (pick_idx[p] == PW'(NUM_FU - 1)) ? '0 : pick_idx[p] + 1'b1;
                end
            end
        end
    end

    // Round-robin pointer; holds when nothing was granted or on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef CDB_ARB_OUT_REG_EN
    cdb_entry_t         cdb_out_q [NUM_CDB];
    logic [NUM_CDB-1:0] cdb_valid_q;

    // Registered broadcast stage; a flush empties it on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= '0;
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_out_q[p] <= '0;
            end
        end else if (flush) begin
            cdb_valid_q <= '0;
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_out_q[p] <= '0;
            end
        end else begin
            cdb_valid_q <= bcast_vld_d;
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_out_q[p] <= bcast_d[p];
            end
        end
    end

    assign cdb_out   = cdb_out_q;
    assign cdb_valid = cdb_valid_q & {NUM_CDB{~flush}};
`else
    assign cdb_out   = bcast_d;
    assign cdb_valid = bcast_vld_d;
`endif

endmodule

// File: doc/cdb_rr_arb.md
CDB_RR_ARB -- requirements
Module: cdb_rr_arb

Interface
REQ-001 Parameter NUM_FU, default 4: number of requesting functional units; legal range 2..16, any value, power of two not required.
REQ-002 Parameter NUM_CDB, default 2: number of broadcast ports per cycle; legal range 1..NUM_FU.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fu_valid  in  [NUM_FU] x 1  FU i holds a completed result.
REQ-006 fu_entry  in  [NUM_FU] x cdb_entry_t  result payload of FU i.
REQ-007 fu_grant  out  [NUM_FU] x 1  FU i result accepted this cycle.
REQ-008 flush  in  1  branch mispredict; squash arbitration this cycle.
REQ-009 cdb_out  out  [NUM_CDB] x cdb_entry_t  broadcast payload per port.
REQ-010 cdb_valid  out  [NUM_CDB] x 1  port p carries a valid broadcast.
REQ-011 grant_cnt  out  $clog2(NUM_CDB+1)  number of grants issued this cycle.

Function
REQ-012 Arbitration: round-robin; scan from rr_ptr upward modulo NUM_FU; the first NUM_CDB indices with fu_valid=1 are granted.
REQ-013 Port mapping: k-th granted FU in scan order drives cdb_out[k]; ports beyond the grant count drive all-zero payload with cdb_valid=0.
REQ-014 Handshake: transfer occurs when fu_valid & fu_grant; FU holds fu_valid and fu_entry stable until granted; fu_grant never asserts without fu_valid.
REQ-015 fu_grant and grant_cnt are combinational from fu_valid, rr_ptr, flush in both configurations.
REQ-016 rr_ptr width $clog2(NUM_FU); after a cycle with >=1 grant, rr_ptr <= (last granted index + 1) mod NUM_FU; wrap from NUM_FU-1 to 0 for non-power-of-two NUM_FU.
REQ-017 No grants in a cycle: rr_ptr holds.
REQ-018 flush=1: all fu_grant=0, grant_cnt=0, all cdb_valid=0 that cycle, rr_ptr holds.
REQ-019 Fewer requesters than ports: all requesters granted same cycle; no duplicate grants.
REQ-020 Fairness: a continuously valid FU is granted within ceil(NUM_FU/NUM_CDB) cycles absent flush.

Reset
REQ-021 rst_n low: rr_ptr=0, all output registers cleared, fu_grant=0, cdb_valid=0, cdb_out=0, grant_cnt=0, asynchronously.
REQ-022 Reset asserted mid-operation discards any registered broadcast; first arbitration after deassertion starts at index 0.

Configuration
REQ-023 Macro CDB_ARB_OUT_REG_EN defined: cdb_out/cdb_valid registered; broadcast appears one cycle after grant; flush clears the registers on the clock edge and masks cdb_valid combinationally in its own cycle.
REQ-024 Macro CDB_ARB_OUT_REG_EN undefined: cdb_out/cdb_valid combinational, same cycle as grant; no output registers.

Structure
REQ-025 cdb_entry_t (valid, rob_idx, pd, rd, value) and CDB width constants live in rv32i_types; module imports it.
REQ-026 One sub-module, cdb_rr_pick: given request vector and start pointer, returns up to NUM_CDB one-hot picks in scan order; instantiated once.

Verification
REQ-027 NUM_FU=4, NUM_CDB=2, rr_ptr=0, fu_valid=1111 -> grants FU0->port0, FU1->port1, rr_ptr=2; next cycle FU2, FU3, rr_ptr=0.
REQ-028 NUM_FU=4, NUM_CDB=2, rr_ptr=3, fu_valid=1001 -> FU3->port0, FU0->port1, rr_ptr=1, grant_cnt=2.
REQ-029 fu_valid=0100, flush=1 -> fu_grant=0000, cdb_valid=00, rr_ptr unchanged; flush=0 next cycle -> FU2 granted.
REQ-030 NUM_FU=5, NUM_CDB=1, all valid, 10 cycles -> grant order 0,1,2,3,4,0,1,2,3,4.
REQ-031 CDB_ARB_OUT_REG_EN: grant FU1 at cycle t, payload 0xDEADBEEF -> cdb_valid[0]=1 with that payload at t+1; flush at t+1 -> cdb_valid[0]=0 at t+1.
REQ-032 rst_n pulsed low mid-stream with rr_ptr=2 -> outputs zero immediately; after release, fu_valid=1111 grants FU0, FU1.
